pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central sequencer for front-end pipeline registers (PC, IF/ID, ID/EX). Detects load-use
//  hazards, branch flushes (ID predict-taken, EX mispredict) and memory freezes; drives
//  stall/flush strobes each cycle. Counts stall/flush/freeze cycles; watchdog halts core
//  on a hung memory. Sits beside the ID stage; outputs feed PC, IF/ID, ID/EX.
// PARAMETERS
//  CNT_W      32   width of each saturating performance counter
//  TIMEOUT    255  max consecutive mem_busy cycles before halt (1..2^TO_W-1)
//  TO_W       8    width of watchdog counter
// PORTS
//  clk_i          in   1      clock; all state updates on posedge
//  start_i        in   1      reset, synchronous, active-low (0 = reset at next posedge)
//  id_rs1_i       in   5      rs1 of instruction in ID
//  id_rs2_i       in   5      rs2 of instruction in ID
//  ex_rd_i        in   5      rd of instruction in EX
//  ex_memread_i   in   1      EX instruction is a load
//  id_pred_tk_i   in   1      ID branch predicted taken
//  ex_mispred_i   in   1      EX branch resolved opposite to prediction
//  mem_busy_i     in   1      data memory not ready; whole pipe must freeze
//  halt_req_i     in   1      external halt request
//  pc_write_o     out  1      1 = PC may update
//  ifid_stall_o   out  1      IF/ID holds contents
//  ifid_flush_o   out  1      IF/ID loads zero (NOP)
//  idex_flush_o   out  1      ID/EX loads bubble
//  flush_ex_o     out  1      EX-stage flush (mispredict path), to IF/ID Flush_EX input
//  state_o        out  2      current FSM state
//  timeout_o      out  1      sticky; watchdog fired
//  stall_cnt_o    out  CNT_W  load-use stall cycles
//  flush_cnt_o    out  CNT_W  cycles with ifid_flush_o=1
//  freeze_cnt_o   out  CNT_W  cycles spent in FREEZE
// BEHAVIOUR
//  - FSM states: RUN=0, FREEZE=1, HALT=3. Reset -> RUN; counters, watchdog, timeout_o = 0.
//  - Outputs combinational from state + inputs (zero latency, same cycle).
//    Counters/watchdog/state registered.
//  - Load-use: lu = ex_memread_i & (ex_rd_i!=0) & (ex_rd_i==id_rs1_i | ex_rd_i==id_rs2_i).
//  - Priority in RUN (highest first):
//    1 mem_busy_i      -> pc_write=0, ifid_stall=1, idex_flush=0, flushes=0; next FREEZE
//    2 ex_mispred_i    -> ifid_flush=1, flush_ex=1, idex_flush=1, pc_write=1, stall=0
//    3 lu              -> pc_write=0, ifid_stall=1, idex_flush=1
//    4 id_pred_tk_i    -> ifid_flush=1, pc_write=1
//    5 none            -> pc_write=1, all others 0
//    halt_req_i in RUN (any priority) -> next HALT; current-cycle outputs per table above.
//  - FREEZE: pc_write=0, ifid_stall=1, no flushes, no bubble; held hazard inputs ignored.
//    Watchdog increments each FREEZE cycle. mem_busy_i=0 -> RUN, watchdog cleared; the
//    first RUN cycle re-evaluates hazards (held mispredict/lu acted on then).
//    Watchdog reaching TIMEOUT with mem_busy_i still 1 -> HALT, timeout_o=1.
//  - HALT: pc_write=0, ifid_stall=1, idex_flush=1; absorbing, exits only by reset.
//  - Counters saturate at all-ones; stall_cnt +1 per cycle in RUN with priority-3 action;
//    flush_cnt +1 per cycle ifid_flush_o=1; freeze_cnt +1 per cycle state==FREEZE.
//  - Reset asserted mid-FREEZE/HALT: next cycle RUN, all counters 0.
//  - ifid_stall_o and ifid_flush_o never both 1.
// STRUCTURE
//  - Shared pkg (cpu_ctrl_pkg / `define header): state encodings, REG_ZERO=5'd0.
//  - One sub-module: sat_counter (CNT_W, en -> +1 saturating, sync active-low clear),
//    instantiated 3x.
//  - Hazard detect + priority mux inline; FSM + watchdog in one always block.
// TESTING
//  1 ex_memread=1, ex_rd=5, id_rs1=5 -> same cycle pc_write=0, ifid_stall=1, idex_flush=1;
//    stall_cnt=1.
//  2 ex_rd=0, ex_memread=1, id_rs1=0 -> no stall; pc_write=1.
//  3 ex_mispred=1 with lu true -> ifid_flush=1, flush_ex=1, ifid_stall=0; flush_cnt=1.
//  4 mem_busy 4 cycles -> state FREEZE 4 cycles, freeze_cnt=4, then RUN, timeout_o=0.
//  5 TIMEOUT=3, mem_busy held -> after 3 FREEZE cycles state=HALT, timeout_o=1 until
//    start_i=0.
//  6 start_i=0 during FREEZE (freeze_cnt=2) -> next cycle RUN, all counters 0,
//    pc_write=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared constants and helpers for the front-end hazard
//               sequencer: FSM state encodings, the hard-wired zero register
//               index and the load-use hazard detect function.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    // FSM state encodings (value 2 is unused and handled as HALT)
    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_FREEZE = 2'd1;
    localparam logic [1:0] c_ST_HALT   = 2'd3;

    // x0 is hard-wired to zero, so a load into it can never create a hazard
    localparam logic [4:0] c_REG_ZERO  = 5'd0;

    // Load in EX whose destination is a source of the instruction in ID
    function automatic logic f_load_use(
        input logic       memread,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return memread && (rd != c_REG_ZERO) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage : pipeline_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous active-low clear.
//               Increments by one per enabled cycle and sticks at all-ones.
// Ports       : clk      - clock
//               i_clr_n  - synchronous clear, active low
//               i_en     - count enable
//               o_count  - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             i_clr_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central sequencer for the front-end pipeline registers
//               (PC, IF/ID, ID/EX). Detects load-use hazards, branch flushes
//               and memory freezes, drives the stall/flush strobes in the same
//               cycle, keeps saturating performance counters and halts the
//               core through a watchdog when memory stays busy too long.
// Ports       : clk_i          - clock
//               start_i        - synchronous reset, active low
//               id_rs1_i/rs2_i - source registers of the instruction in ID
//               ex_rd_i        - destination register of the instruction in EX
//               ex_memread_i   - EX instruction is a load
//               id_pred_tk_i   - ID branch predicted taken
//               ex_mispred_i   - EX branch mispredicted
//               mem_busy_i     - data memory not ready
//               halt_req_i     - external halt request
//               pc_write_o, ifid_stall_o, ifid_flush_o, idex_flush_o,
//               flush_ex_o     - pipeline register controls
//               state_o        - FSM state
//               timeout_o      - sticky watchdog flag
//               stall_cnt_o, flush_cnt_o, freeze_cnt_o - performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic             clk_i,
    input  logic             start_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_memread_i,
    input  logic             id_pred_tk_i,
    input  logic             ex_mispred_i,
    input  logic             mem_busy_i,
    input  logic             halt_req_i,
    output logic             pc_write_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             flush_ex_o,
    output logic [1:0]       state_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] freeze_cnt_o
);

    localparam logic [TO_W-1:0] c_TIMEOUT = TO_W'(TIMEOUT);

    logic [1:0]      r_state;
    logic [TO_W-1:0] r_wdog;
    logic            r_timeout;

    logic            w_lu;
    logic            w_lu_stall;
    logic [TO_W-1:0] w_wdog_inc;

    assign w_lu       = f_load_use(ex_memread_i, ex_rd_i, id_rs1_i, id_rs2_i);
    // Watchdog never exceeds TIMEOUT, so the increment cannot wrap
    assign w_wdog_inc = r_wdog + 1'b1;

    // ------------------------------------------------------------------
    // Strobe generation: purely a function of state and current inputs
    // ------------------------------------------------------------------
    always_comb begin
        pc_write_o   = 1'b0;
        ifid_stall_o = 1'b0;
        ifid_flush_o = 1'b0;
        idex_flush_o = 1'b0;
        flush_ex_o   = 1'b0;
        w_lu_stall   = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (mem_busy_i) begin
                    // Freeze everything; no bubble so the EX instruction survives
                    ifid_stall_o = 1'b1;
                end else if (ex_mispred_i) begin
                    // Wrong path: squash both younger stages, redirect the PC
                    pc_write_o   = 1'b1;
                    ifid_flush_o = 1'b1;
                    flush_ex_o   = 1'b1;
                    idex_flush_o = 1'b1;
                end else if (w_lu) begin
                    ifid_stall_o = 1'b1;
                    idex_flush_o = 1'b1;
                    w_lu_stall   = 1'b1;
                end else if (id_pred_tk_i) begin
                    pc_write_o   = 1'b1;
                    ifid_flush_o = 1'b1;
                end else begin
                    pc_write_o   = 1'b1;
                end
            end
            c_ST_FREEZE: begin
                // Hazard inputs are ignored here and re-evaluated on return to RUN
                ifid_stall_o = 1'b1;
            end
            default: begin
                // HALT (and the unused encoding): hold fetch, keep bubbling EX
                ifid_stall_o = 1'b1;
                idex_flush_o = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM and watchdog
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            r_state   <= c_ST_RUN;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    r_wdog <= '0;
                    if (halt_req_i) begin
                        r_state <= c_ST_HALT;
                    end else if (mem_busy_i) begin
                        r_state <= c_ST_FREEZE;
                    end
                end
                c_ST_FREEZE: begin
                    if (!mem_busy_i) begin
                        r_state <= c_ST_RUN;
                        r_wdog  <= '0;
                    end else begin
                        r_wdog <= w_wdog_inc;
                        if (w_wdog_inc == c_TIMEOUT) begin
                            r_state   <= c_ST_HALT;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                c_ST_HALT: begin
                    r_state <= c_ST_HALT;
                end
                default: begin
                    r_state <= c_ST_HALT;
                end
            endcase
        end
    end

    assign state_o   = r_state;
    assign timeout_o = r_timeout;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk_i),
        .i_clr_n (start_i),
        .i_en    (w_lu_stall),
        .o_count (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk_i),
        .i_clr_n (start_i),
        .i_en    (ifid_flush_o),
        .o_count (flush_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
        .clk     (clk_i),
        .i_clr_n (start_i),
        .i_en    (r_state == c_ST_FREEZE),
        .o_count (freeze_cnt_o)
    );

endmodule : pipeline_hazard_ctrl
`default_nettype wire
